// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch sequencer for rv_cpu. Owns the PC, keeps at most one
// instruction-memory request outstanding, and holds the returned word in a
// single output register that feeds the decoder. A taken branch/jump
// (redirect) squashes the buffered word and any request already in flight.
//
// Handshake rule used on every interface of this block: a transfer happens in
// a cycle where both sides' valid and ready are high at the rising edge of
// CLK. imem_req + imem_ready is a request acceptance; inst_valid + dec_ready
// is a decoder transfer. The valid side never depends combinationally on the
// ready side. imem_rvalid has no backpressure and arrives exactly once per
// accepted request.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   imem_req        request valid to instruction memory (state == REQ)
//   imem_addr       request byte address, always word aligned (== pc)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     response valid
//   imem_rdata      response instruction word
//   redirect_valid  branch/jump taken this cycle
//   redirect_pc     redirect target (low two bits ignored)
//   inst_valid      buffered instruction valid to decoder
//   inst_data       buffered instruction word
//   inst_pc         PC of inst_data
//   dec_ready       decoder accepts the buffered instruction
//   fetch_count     completed decoder transfers, wraps at 2^CNT_W
//   dbg_state       current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             inst_valid,
  output logic [31:0]      inst_data,
  output logic [31:0]      inst_pc,
  input  logic             dec_ready,
  output logic [CNT_W-1:0] fetch_count,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t             r_state;
  logic [31:0]        r_pc;
  logic               r_inst_valid;
  logic [31:0]        r_inst_data;
  logic [31:0]        r_inst_pc;
  logic [CNT_W-1:0]   r_fetch_count;

  state_t             w_state_next;
  logic [31:0]        w_pc_next;
  logic               w_inst_valid_next;
  logic [31:0]        w_inst_data_next;
  logic [31:0]        w_inst_pc_next;
  logic [CNT_W-1:0]   w_fetch_count_next;

  logic               w_accept;
  logic               w_xfer;
  logic [31:0]        w_target;

  assign w_accept = (r_state == S_REQ) && imem_ready;
  assign w_xfer   = r_inst_valid && dec_ready;
  assign w_target = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_inst_valid_next  = r_inst_valid;
    w_inst_data_next   = r_inst_data;
    w_inst_pc_next     = r_inst_pc;
    // A transfer always counts, even when a redirect flushes the same cycle.
    w_fetch_count_next = w_xfer ? (r_fetch_count + CNT_W'(1)) : r_fetch_count;

    case (r_state)
      S_IDLE: w_state_next = S_REQ;
      S_REQ: begin
        if (w_accept) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_inst_data_next  = imem_rdata;
          w_inst_pc_next    = r_pc;
          w_inst_valid_next = 1'b1;
          w_pc_next         = r_pc + 32'd4;
          w_state_next      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (dec_ready) begin
          w_inst_valid_next = 1'b0;
          w_state_next      = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) w_state_next = S_REQ;
      end
      default: w_state_next = S_IDLE;
    endcase

    // Redirect overrides everything above. Any response captured this cycle
    // is stale, so the output buffer keeps its old (now invalid) contents.
    // If a request is, or is about to be, outstanding we must swallow its
    // response in DRAIN before issuing the request at the new target.
    if (redirect_valid) begin
      w_pc_next         = w_target;
      w_inst_valid_next = 1'b0;
      w_inst_data_next  = r_inst_data;
      w_inst_pc_next    = r_inst_pc;
      case (r_state)
        S_REQ:   w_state_next = w_accept    ? S_DRAIN : S_REQ;
        S_WAIT:  w_state_next = imem_rvalid ? S_REQ   : S_DRAIN;
        S_DRAIN: w_state_next = imem_rvalid ? S_REQ   : S_DRAIN;
        default: w_state_next = S_REQ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_inst_valid  <= 1'b0;
      r_inst_data   <= 32'd0;
      r_inst_pc     <= 32'd0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_inst_valid  <= w_inst_valid_next;
      r_inst_data   <= w_inst_data_next;
      r_inst_pc     <= w_inst_pc_next;
      r_fetch_count <= w_fetch_count_next;
    end
  end

  // Memory interface is a pure decode of registered state; the address may
  // move while a request is stalled, memory samples it only on acceptance.
  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign inst_valid  = r_inst_valid;
  assign inst_data   = r_inst_data;
  assign inst_pc     = r_inst_pc;
  assign fetch_count = r_fetch_count;
  assign dbg_state   = r_state;

endmodule
